led_code_sequencer: RTL and testbench
=====================================

Name: led_code_sequencer

Overview:
- Controller that owns the board LED. By default it drives a heartbeat blink.
- On request it plays a blink code of N pulses, inserts a gap, then returns to heartbeat.
- Requesters hand over codes through a valid/ready handshake. A force input overrides the LED without disturbing sequencing.
- Sits between status/error sources and the LED pin, replacing the free-running counter drive.

Parameters:
TICK_DIV, 1200000, CLK cycles per timing tick (100 ms at 12 MHz); must be >= 1
ON_TICKS, 2, ticks LED is high per code pulse; must be >= 1
OFF_TICKS, 3, ticks LED is low between code pulses; must be >= 1
GAP_TICKS, 10, extra low ticks after the last pulse before heartbeat resumes; must be >= 1
HB_HALF_TICKS, 5, ticks per heartbeat half-period; must be >= 1
CODE_W, 4, width of the code count

Ports:
CLK  in  1  system clock, all logic on rising edge
RESETN  in  1  synchronous active-low reset
REQ_VALID  in  1  code request valid
REQ_READY  out  1  controller can accept a code
REQ_CODE  in  CODE_W  number of pulses to play; 0 = no-op
FORCE_ON  in  1  LED forced high while asserted
BUSY  out  1  code sequence in progress
LED  out  1  LED drive, registered

Behaviour:
- Interface: one clock, CLK. Reset RESETN is synchronous, active-low. All state is sampled on the CLK rising edge when RESETN=0.
- Reset values: state=HB, divider=0, phase timer=0, remaining=0, LED=0, BUSY=0. REQ_READY=0 while RESETN=0.
- Tick generator:
  - Divider counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse when divider==TICK_DIV-1.
  - Divider clears synchronously on request acceptance and on GAP->HB.
- States: HB, ON, OFF, GAP. Phase timer counts ticks within the current state and clears on every transition.
- HB:
  - LED level toggles each time the timer reaches HB_HALF_TICKS, then the timer clears.
  - After reset, the first rise is at HB_HALF_TICKS*TICK_DIV cycles.
- Handshake:
  - REQ_READY = (state==HB) & RESETN.
  - Transfer occurs when REQ_VALID & REQ_READY on a clock edge.
  - REQ_VALID while BUSY is not accepted and is not lost; it is accepted on the first HB cycle.
- Accept with REQ_CODE==0: transfer completes. State, divider, timers and heartbeat phase are unchanged.
- Accept with REQ_CODE=N>0:
  - remaining<=N; ->ON. Divider and timer clear; the heartbeat level is discarded.
  - LED=1 from the next cycle. BUSY=1 from the next cycle.
- ON: after ON_TICKS ticks (exactly ON_TICKS*TICK_DIV cycles) ->OFF, remaining<=remaining-1.
- OFF: after OFF_TICKS ticks, ->GAP if remaining==0, else ->ON.
- GAP:
  - After GAP_TICKS ticks ->HB. Heartbeat restarts at LED level 0, timer 0.
  - BUSY=0 and REQ_READY=1 in the first HB cycle.
- Total low time after the last pulse = (OFF_TICKS+GAP_TICKS)*TICK_DIV cycles.
- FORCE_ON:
  - LED register loads 1 while FORCE_ON=1 (1-cycle latency).
  - The state machine and timers run unaffected.
  - On release, LED shows the underlying sequence level from the next cycle.
- Reset mid-operation (any state): next cycle is the reset state. Any in-flight code is discarded.
- Widths:
  - remaining is CODE_W bits.
  - Phase timer is wide enough for the max of ON/OFF/GAP/HB_HALF ticks.
  - Divider is $clog2(TICK_DIV) bits, minimum 1.
  - No overflow is possible by construction.

Decomposition:
- Shared package/include led_pkg holds:
  - state encoding constants ST_HB, ST_ON, ST_OFF, ST_GAP (2 bits);
  - default timing constants.
- One sub-module, led_tick_gen (parameter TICK_DIV; ports CLK, RESETN, CLR, TICK). It is also reusable by other blink/timing blocks.
- Timer, FSM, LED register and handshake live in the top.

Test Plan:
All scenarios use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, GAP_TICKS=10, HB_HALF_TICKS=5.
1. Reset:
   - Hold RESETN=0 for 5 cycles -> LED=0, REQ_READY=0, BUSY=0.
   - After release, LED rises at cycle 20 and falls at cycle 40; REQ_READY=1 from the first cycle after release.
2. Accept code 3:
   - LED high 8 cycles, low 12 cycles; three pulses total.
   - After the third pulse, LED low 52 cycles, then HB with first rise 20 cycles later.
   - BUSY high from the cycle after accept until the HB entry cycle.
3. Code 0 accepted at cycle 10 after reset -> REQ_READY stays 1, BUSY stays 0, LED still rises at cycle 20.
4. Back-to-back:
   - Hold REQ_VALID with code 1, then code 2 held -> REQ_READY=0 throughout the code-1 sequence.
   - Code 2 is accepted in the first HB cycle; exactly 2 pulses follow.
5. Reset mid-pulse: RESETN=0 during the 2nd ON of code 5 -> next cycle LED=0, BUSY=0. After release, heartbeat timing is as in scenario 1.
6. Force during OFF:
   - FORCE_ON=1 for 6 cycles during an OFF phase -> LED=1 one cycle after assertion.
   - On release, LED returns to 0. Subsequent pulse edges occur at the same cycles as without force.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED code sequencer family: FSM state encoding,
// default timing and a small helper for sizing the phase timer.
package led_pkg;

    localparam logic [1:0] ST_HB  = 2'd0;
    localparam logic [1:0] ST_ON  = 2'd1;
    localparam logic [1:0] ST_OFF = 2'd2;
    localparam logic [1:0] ST_GAP = 2'd3;

    // Defaults give 100 ms ticks at 12 MHz.
    localparam int DEF_TICK_DIV      = 1200000;
    localparam int DEF_ON_TICKS      = 2;
    localparam int DEF_OFF_TICKS     = 3;
    localparam int DEF_GAP_TICKS     = 10;
    localparam int DEF_HB_HALF_TICKS = 5;
    localparam int DEF_CODE_W        = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timing tick generator: divider counts 0..TICK_DIV-1 and emits a one-cycle
// TICK on the last count. CLR restarts the count so a new phase starts aligned.
module led_tick_gen #(
    parameter int TICK_DIV = led_pkg::DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic CLR,
    output logic TICK
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign TICK = (div_q == DIV_LAST);

    // Next divider value: wrap on the last count, restart on CLR.
    always_comb begin
        // NOTE: assign a default first so every path drives div_d and no latch is inferred.
        div_d = div_q + 1'b1;
        if (CLR || TICK) div_d = '0;
    end

    // Divider register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RESETN) div_q <= '0;
        else         div_q <= div_d;
    end

endmodule

// File: rtl/led_code_sequencer.sv
// LED owner: heartbeat blink by default, plays an N-pulse blink code on request,
// then a low gap, then back to heartbeat. FORCE_ON overrides only the LED flop.
module led_code_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int ON_TICKS      = DEF_ON_TICKS,
    parameter int OFF_TICKS     = DEF_OFF_TICKS,
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int HB_HALF_TICKS = DEF_HB_HALF_TICKS,
    parameter int CODE_W        = DEF_CODE_W
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [CODE_W-1:0] REQ_CODE,
    input  logic              FORCE_ON,
    output logic              BUSY,
    output logic              LED
);

    localparam int T_MAX = max4(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_HALF_TICKS);
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    // Last timer value of each phase; the phase ends on the tick that sees it.
    localparam logic [TMR_W-1:0] LAST_HB  = TMR_W'(HB_HALF_TICKS - 1);
    localparam logic [TMR_W-1:0] LAST_ON  = TMR_W'(ON_TICKS - 1);
    localparam logic [TMR_W-1:0] LAST_OFF = TMR_W'(OFF_TICKS - 1);
    localparam logic [TMR_W-1:0] LAST_GAP = TMR_W'(GAP_TICKS - 1);

    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;
    logic [CODE_W-1:0] rem_q,   rem_d;
    logic              hb_q,    hb_d;
    logic              led_q,   led_d;

    logic              tick;
    logic              div_clr;
    logic              accept_nz;
    logic              phase_done;
    logic [TMR_W-1:0]  phase_last;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CLR    (div_clr),
        .TICK   (tick)
    );

    assign REQ_READY = (state_q == ST_HB) && RESETN;
    assign BUSY      = (state_q != ST_HB);
    assign LED       = led_q;

    // A zero code completes the handshake but leaves every bit of state alone.
    assign accept_nz = REQ_VALID && REQ_READY && (REQ_CODE != '0);

    // Select the terminal timer count for the current phase.
    always_comb begin
        phase_last = LAST_HB;
        case (state_q)
            ST_ON:   phase_last = LAST_ON;
            ST_OFF:  phase_last = LAST_OFF;
            ST_GAP:  phase_last = LAST_GAP;
            default: phase_last = LAST_HB;
        endcase
    end

    assign phase_done = tick && (tmr_q == phase_last);

    // Sequencing FSM, phase timer, pulse counter and heartbeat level.
    always_comb begin
        state_d = state_q;
        tmr_d   = tick ? tmr_q + 1'b1 : tmr_q;
        rem_d   = rem_q;
        hb_d    = hb_q;
        div_clr = 1'b0;
        case (state_q)
            ST_HB: begin
                if (accept_nz) begin
                    // New code wins over a coincident heartbeat tick.
                    state_d = ST_ON;
                    tmr_d   = '0;
                    rem_d   = REQ_CODE;
                    hb_d    = 1'b0;
                    div_clr = 1'b1;
                end else if (phase_done) begin
                    hb_d  = ~hb_q;
                    tmr_d = '0;
                end
            end
            ST_ON: begin
                if (phase_done) begin
                    state_d = ST_OFF;
                    tmr_d   = '0;
                    rem_d   = rem_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (phase_done) begin
                    state_d = (rem_q == '0) ? ST_GAP : ST_ON;
                    tmr_d   = '0;
                end
            end
            default: begin
                if (phase_done) begin
                    // Heartbeat restarts low with a freshly aligned divider.
                    state_d = ST_HB;
                    tmr_d   = '0;
                    hb_d    = 1'b0;
                    div_clr = 1'b1;
                end
            end
        endcase
        // LED follows the level of the state being entered, so it is registered
        // yet shows the new phase on the first cycle of that phase.
        led_d = FORCE_ON || (state_d == ST_ON) || ((state_d == ST_HB) && hb_d);
    end

    // Controller state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_HB;
            tmr_q   <= '0;
            rem_q   <= '0;
            hb_q    <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            hb_q    <= hb_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_led_code_sequencer.sv
// Self-checking bench for led_code_sequencer: directed scenarios followed by
// random traffic, all compared every cycle against a cycle-count reference model.
module tb_led_code_sequencer;

    localparam int D    = 4;
    localparam int ON   = 2;
    localparam int OFF  = 3;
    localparam int GAP  = 10;
    localparam int HALF = 5;
    localparam int P    = (ON + OFF) * D;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic [3:0] REQ_CODE = 4'd0;
    logic       FORCE_ON = 1'b0;
    logic       REQ_READY;
    logic       BUSY;
    logic       LED;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: either playing a code (m_t cycles since the first ON
    // cycle, m_n pulses) or in heartbeat (m_hb cycles since heartbeat start).
    bit m_seq = 1'b0;
    int m_t   = 0;
    int m_n   = 0;
    int m_hb  = 0;
    bit m_fp  = 1'b0;

    always #5 CLK = ~CLK;

    led_code_sequencer #(
        .TICK_DIV      (D),
        .ON_TICKS      (ON),
        .OFF_TICKS     (OFF),
        .GAP_TICKS     (GAP),
        .HB_HALF_TICKS (HALF),
        .CODE_W        (4)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_CODE  (REQ_CODE),
        .FORCE_ON  (FORCE_ON),
        .BUSY      (BUSY),
        .LED       (LED)
    );

    function automatic bit m_level();
        if (m_seq) return (m_t < m_n * P) && ((m_t % P) < ON * D);
        return ((m_hb / (HALF * D)) % 2) == 1;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (!RESETN) begin
            m_seq = 1'b0;
            m_hb  = 0;
            m_fp  = 1'b0;
        end else begin
            m_fp = FORCE_ON;
            if (!m_seq) begin
                if (REQ_VALID && (REQ_CODE != 4'd0)) begin
                    m_seq = 1'b1;
                    m_t   = 0;
                    m_n   = int'(REQ_CODE);
                end else begin
                    m_hb++;
                end
            end else begin
                m_t++;
                if (m_t == m_n * P + GAP * D) begin
                    m_seq = 1'b0;
                    m_hb  = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, move to the next negedge.
    task automatic cycle(input logic v, input logic [3:0] code, input logic f, input logic r);
        REQ_VALID = v;
        REQ_CODE  = code;
        FORCE_ON  = f;
        RESETN    = r;
        #1;
        check("led",   LED,       m_fp | m_level());
        check("busy",  BUSY,      m_seq);
        check("ready", REQ_READY, !m_seq && r);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge CLK);

        // Reset and free heartbeat.
        do_reset(5);
        idle(45);

        // Code 3 then full return to heartbeat.
        do_reset(2);
        idle(5);
        cycle(1'b1, 4'd3, 1'b0, 1'b1);
        idle(130);

        // Code 0 at cycle 10 after reset is a no-op.
        do_reset(2);
        idle(10);
        cycle(1'b1, 4'd0, 1'b0, 1'b1);
        idle(40);

        // Back-to-back: code 2 held valid through the code-1 sequence.
        do_reset(2);
        idle(3);
        cycle(1'b1, 4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 61; i++) cycle(1'b1, 4'd2, 1'b0, 1'b1);
        idle(100);

        // Reset during the second ON of code 5.
        do_reset(2);
        idle(2);
        cycle(1'b1, 4'd5, 1'b0, 1'b1);
        idle(23);
        do_reset(3);
        idle(50);

        // Force during an OFF phase of code 2.
        do_reset(2);
        idle(1);
        cycle(1'b1, 4'd2, 1'b0, 1'b1);
        idle(10);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'd0, 1'b1, 1'b1);
        idle(80);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic       v;
            logic [3:0] c;
            logic       f;
            logic       r;
            v = ($urandom_range(0, 9) == 0);
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 2));
            f = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 599) != 0);
            cycle(v, c, f, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
